// File: rtl/mac_pkg.sv
// Shared types, default sizes and the saturating-add helpers used by the
// multiply-accumulate stage.
package mac_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int ACC_W_DEF = 40;
   localparam int LEN_W_DEF = 8;

   // Widest accumulator the helpers can serve; callers zero-extend into it.
   localparam int SAT_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mac_state_e;

   // Largest value representable in w bits, held in SAT_W+1 bits.
   function automatic logic [SAT_W:0] sat_limit(input int w);
      logic [SAT_W:0] one_s;
      one_s = {{SAT_W{1'b0}}, 1'b1};
      return (one_s << w) - one_s;
   endfunction

   // Sum of a and b clamped to the w-bit maximum.
   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                input logic [SAT_W-1:0] b,
                                                input int w);
      logic [SAT_W:0] sum_s;
      logic [SAT_W:0] lim_s;
      sum_s = {1'b0, a} + {1'b0, b};
      lim_s = sat_limit(w);
      if (sum_s > lim_s) begin
         return lim_s[SAT_W-1:0];
      end else begin
         return sum_s[SAT_W-1:0];
      end
   endfunction

   // High when a + b would not fit in w bits.
   function automatic logic sat_hit(input logic [SAT_W-1:0] a,
                                    input logic [SAT_W-1:0] b,
                                    input int w);
      logic [SAT_W:0] sum_s;
      sum_s = {1'b0, a} + {1'b0, b};
      return (sum_s > sat_limit(w));
   endfunction

endpackage

// File: rtl/array_multiplier_16x16.sv
// Combinational 16x16 unsigned array multiplier: sum of shifted partial
// products, one row per bit of b.
module array_multiplier_16x16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   logic [31:0] sum_s;

   // Accumulate one partial-product row per multiplier bit.
   always_comb begin
      sum_s = 32'd0;
      for (int i = 0; i < 16; i++) begin
         sum_s = sum_s + (b[i] ? ({16'd0, a} << i) : 32'd0);
      end
   end

   assign p = sum_s;

endmodule

// File: rtl/mac_accumulator_16.sv
// Multiply-accumulate stage: registers operand pairs into the array multiplier,
// registers the product and sums it into a saturating accumulator per burst.
module mac_accumulator_16
   import mac_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy
);

   localparam int PROD_W = 2 * WIDTH;
   localparam logic [LEN_W:0] REM_ONE  = {{LEN_W{1'b0}}, 1'b1};
   localparam logic [LEN_W:0] REM_FULL = {1'b1, {LEN_W{1'b0}}};

   mac_state_e        state_r;
   logic [LEN_W:0]    rem_r;
   logic [WIDTH-1:0]  op_a_r;
   logic [WIDTH-1:0]  op_b_r;
   logic              v1_r;
   logic [PROD_W-1:0] prod_s;
   logic [PROD_W-1:0] prod_r;
   logic              v2_r;
   logic [ACC_W-1:0]  acc_r;
   logic              ovf_r;
   logic              accept_s;
   logic [ACC_W-1:0]  acc_next_s;
   logic              sat_hit_s;

   assign accept_s = in_valid && in_ready;

   array_multiplier_16x16 u_mult (
      .a (op_a_r),
      .b (op_b_r),
      .p (prod_s)
   );

   assign acc_next_s = ACC_W'(sat_add(SAT_W'(acc_r), SAT_W'(prod_r), ACC_W));
   assign sat_hit_s  = sat_hit(SAT_W'(acc_r), SAT_W'(prod_r), ACC_W);

   // Burst control: remaining count, state and the handshake/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         rem_r     <= {(LEN_W+1){1'b0}};
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  rem_r    <= (len == {LEN_W{1'b0}}) ? REM_FULL : {1'b0, len};
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state_r  <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept_s) begin
                  rem_r <= rem_r - REM_ONE;
                  if (rem_r == REM_ONE) begin
                     in_ready <= 1'b0;
                     state_r  <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // Both stages empty means the last product has been summed.
               if (!v1_r && !v2_r) begin
                  out_valid <= 1'b1;
                  state_r   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

   // Operand and product stages, each gated by its own valid bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_r <= {WIDTH{1'b0}};
         op_b_r <= {WIDTH{1'b0}};
         v1_r   <= 1'b0;
         prod_r <= {PROD_W{1'b0}};
         v2_r   <= 1'b0;
      end else begin
         v1_r <= accept_s;
         v2_r <= v1_r;
         if (accept_s) begin
            op_a_r <= in_a;
            op_b_r <= in_b;
         end
         if (v1_r) begin
            prod_r <= prod_s;
         end
      end
   end

   // Accumulator and sticky overflow; cleared by an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
         ovf_r <= 1'b0;
      end else if ((state_r == IDLE) && start) begin
         acc_r <= {ACC_W{1'b0}};
         ovf_r <= 1'b0;
      end else if (v2_r) begin
         acc_r <= acc_next_s;
         ovf_r <= ovf_r | sat_hit_s;
      end
   end

   assign out_acc = acc_r;
   assign out_ovf = ovf_r;

endmodule

// File: tb/tb_mac_accumulator_16.sv
// Scoreboard bench for mac_accumulator_16: a default instance and a 33-bit
// accumulator instance share one stimulus path selected by sel.
module tb_mac_accumulator_16;

   typedef struct packed {
      logic [39:0] acc;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_ready;

   logic        m_start, m_in_valid, m_in_ready, m_out_valid, m_out_ovf, m_busy;
   logic [39:0] m_out_acc;
   logic        s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ovf, s_busy;
   logic [32:0] s_out_acc;
   logic        in_ready_s, out_valid_s, busy_s;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int k;
   logic stable;
   exp_t q_main[$];
   exp_t q_sat[$];
   logic [15:0] va[$];
   logic [15:0] vb[$];

   assign m_start    = sel ? 1'b0 : start;
   assign s_start    = sel ? start : 1'b0;
   assign m_in_valid = sel ? 1'b0 : in_valid;
   assign s_in_valid = sel ? in_valid : 1'b0;
   assign in_ready_s  = sel ? s_in_ready : m_in_ready;
   assign out_valid_s = sel ? s_out_valid : m_out_valid;
   assign busy_s      = sel ? s_busy : m_busy;

   mac_accumulator_16 u_dut (
      .clk(clk), .rst_n(rst_n), .start(m_start), .len(len),
      .in_valid(m_in_valid), .in_ready(m_in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(m_out_valid), .out_ready(out_ready), .out_acc(m_out_acc),
      .out_ovf(m_out_ovf), .busy(m_busy)
   );

   mac_accumulator_16 #(.ACC_W(33)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(s_start), .len(len),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
      .out_ovf(s_out_ovf), .busy(s_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitors: every result handshake pops and compares one expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && m_out_valid && out_ready) begin
         checks++;
         if (q_main.size() == 0) begin
            failures++;
            $display("FAIL main_result: got acc=0x%0h ovf=%0b, no result expected", m_out_acc, m_out_ovf);
         end else begin
            e = q_main.pop_front();
            if (m_out_acc !== e.acc || m_out_ovf !== e.ovf) begin
               failures++;
               $display("FAIL main_result: got acc=0x%0h ovf=%0b expected acc=0x%0h ovf=%0b",
                        m_out_acc, m_out_ovf, e.acc, e.ovf);
            end
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && s_out_valid && out_ready) begin
         checks++;
         if (q_sat.size() == 0) begin
            failures++;
            $display("FAIL sat_result: got acc=0x%0h ovf=%0b, no result expected", s_out_acc, s_out_ovf);
         end else begin
            e = q_sat.pop_front();
            if ({7'd0, s_out_acc} !== e.acc || s_out_ovf !== e.ovf) begin
               failures++;
               $display("FAIL sat_result: got acc=0x%0h ovf=%0b expected acc=0x%0h ovf=%0b",
                        s_out_acc, s_out_ovf, e.acc, e.ovf);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
      len   = 8'd0;
   endtask

   // Sends va/vb; optional random gaps; returns the cycle of the last accept.
   task automatic send_burst(input int gap_max, output int last);
      int n;
      logic ok;
      last = 0;
      for (int i = 0; i < va.size(); i++) begin
         if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) tick();
         end
         in_valid = 1'b1;
         in_a = va[i];
         in_b = vb[i];
         n = 0;
         ok = 1'b0;
         while (!ok && n < 50) begin
            ok = in_ready_s;
            tick();
            n++;
         end
         if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: pair %0d not accepted within 50 cycles", i);
         end
         last = cyc;
      end
      in_valid = 1'b0;
      in_a = 16'd0;
      in_b = 16'd0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!out_valid_s && n < 40) begin
         tick();
         n++;
      end
      check(name, 64'(out_valid_s), 64'd1);
   endtask

   task automatic set_pairs_const(input int cnt, input logic [15:0] a, input logic [15:0] b);
      va = {};
      vb = {};
      for (int i = 0; i < cnt; i++) begin
         va.push_back(a);
         vb.push_back(b);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sel = 1'b0; start = 1'b0; len = 8'd0;
      in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; out_ready = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", 64'(m_in_ready), 64'd0);
      check("rst_out_valid", 64'(m_out_valid), 64'd0);
      check("rst_out_acc", 64'(m_out_acc), 64'd0);
      check("rst_out_ovf", 64'(m_out_ovf), 64'd0);
      check("rst_busy", 64'(m_busy), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic burst: 2*3 + 4*5 + 65535*1 = 65561 = 0x10019.
      out_ready = 1'b1;
      va = '{16'd2, 16'd4, 16'hFFFF};
      vb = '{16'd3, 16'd5, 16'd1};
      q_main.push_back({40'h10019, 1'b0});
      do_start(8'd3);
      send_burst(0, k);
      wait_valid("basic_valid");
      check("basic_latency", 64'(cyc - k), 64'd3);
      tick();

      // Full length: 256 * 0xFFFE0001 = 0xFFFE000100.
      set_pairs_const(256, 16'hFFFF, 16'hFFFF);
      q_main.push_back({40'hFFFE000100, 1'b0});
      do_start(8'd0);
      send_burst(0, k);
      wait_valid("full_valid");
      tick();
      set_pairs_const(1, 16'd0, 16'h1234);
      q_main.push_back({40'd0, 1'b0});
      do_start(8'd1);
      send_burst(0, k);
      wait_valid("zero_valid");
      tick();

      // Saturation on the 33-bit instance, then a clean burst.
      sel = 1'b1;
      set_pairs_const(3, 16'hFFFF, 16'hFFFF);
      q_sat.push_back({40'h1FFFFFFFF, 1'b1});
      do_start(8'd3);
      send_burst(0, k);
      wait_valid("sat_valid");
      tick();
      set_pairs_const(1, 16'd1, 16'd1);
      q_sat.push_back({40'd1, 1'b0});
      do_start(8'd1);
      send_burst(0, k);
      wait_valid("sat_clear_valid");
      tick();
      sel = 1'b0;

      // Gap-free reference: 15 + 77 + 221 + 437 = 750.
      va = '{16'd3, 16'd7, 16'd13, 16'd19};
      vb = '{16'd5, 16'd11, 16'd17, 16'd23};
      q_main.push_back({40'd750, 1'b0});
      do_start(8'd4);
      send_burst(0, k);
      wait_valid("nogap_valid");
      tick();

      // Same burst with gaps, stray starts in ACCUM/DRAIN/DONE, held result.
      out_ready = 1'b0;
      do_start(8'd4);
      start = 1'b1; len = 8'd7;
      tick();
      start = 1'b0; len = 8'd0;
      send_burst(3, k);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid("gap_valid");
      check("done_in_ready", 64'(in_ready_s), 64'd0);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         tick();
         if (!out_valid_s || m_out_acc !== 40'd750) stable = 1'b0;
      end
      start = 1'b0;
      check("hold_stable", 64'(stable), 64'd1);
      q_main.push_back({40'd750, 1'b0});
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b0;
      check("done_start_ignored", 64'(busy_s), 64'd0);
      tick();
      check("idle_stays_idle", 64'(busy_s), 64'd0);

      // Ready protocol on a len=2 burst: 1 + 4 = 5.
      check("idle_in_ready", 64'(in_ready_s), 64'd0);
      do_start(8'd2);
      check("accum_in_ready", 64'(in_ready_s), 64'd1);
      va = '{16'd1, 16'd2};
      vb = '{16'd1, 16'd2};
      send_burst(0, k);
      check("ready_drop", 64'(in_ready_s), 64'd0);
      check("drain_busy", 64'(busy_s), 64'd1);
      tick();
      check("drain_in_ready", 64'(in_ready_s), 64'd0);
      wait_valid("ready_valid");
      q_main.push_back({40'd5, 1'b0});
      out_ready = 1'b1;
      tick();

      // Reset after 2 of 5 accepts; acc already holds 1 + 4.
      do_start(8'd5);
      send_burst(0, k);
      repeat (3) tick();
      check("pre_rst_acc", 64'(m_out_acc), 64'd5);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", 64'(m_in_ready), 64'd0);
      check("mid_rst_out_valid", 64'(m_out_valid), 64'd0);
      check("mid_rst_out_acc", 64'(m_out_acc), 64'd0);
      check("mid_rst_out_ovf", 64'(m_out_ovf), 64'd0);
      check("mid_rst_busy", 64'(m_busy), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      set_pairs_const(1, 16'd7, 16'd6);
      q_main.push_back({40'd42, 1'b0});
      do_start(8'd1);
      send_burst(0, k);
      wait_valid("post_rst_valid");
      tick();
      out_ready = 1'b0;
      repeat (2) tick();

      check("main_queue_empty", 64'(q_main.size()), 64'd0);
      check("sat_queue_empty", 64'(q_sat.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
